// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: circular buffer of {pc, instr} with RV32I field/immediate decode of the head entry.
// Latency: push to out_valid 1 cycle; with IF_ID_QUEUE_BYPASS_EN an empty queue forwards the input in the same cycle.
// Backpressure: in_ready = not full or decode popping this cycle; flush empties the queue at the next edge.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          imem_rdata_out,
  output logic [6:0]               opcode,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [31:0]              i_imm,
  output logic [31:0]              s_imm,
  output logic [31:0]              b_imm,
  output logic [31:0]              u_imm,
  output logic [31:0]              j_imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  logic empty;
  logic full;
  logic byp;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic [31:0] iw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
  // Forward the fetch stage straight to decode when nothing is queued; a redirect or reset kills it.
  assign byp = empty && in_valid && !flush && rst;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = !empty || byp;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A bypassed entry taken by decode never touches storage.
  assign wr_en     = push && !(byp && out_ready) && !flush;
  assign rd_en     = pop && !empty && !flush;
  assign count     = cnt;

  // Head mux: stored entry, else bypassed input, else NOP with PC 0.
  always_comb begin
    pc_out         = '0;
    imem_rdata_out = NOP;
    if (!empty) begin
      pc_out         = pc_mem[rd_ptr];
      imem_rdata_out = ins_mem[rd_ptr];
    end else if (byp) begin
      pc_out         = pc_in;
      imem_rdata_out = imem_rdata;
    end
  end

  // RV32I field and immediate extraction from the head instruction word.
  always_comb begin
    iw     = imem_rdata_out[31:0];
    opcode = iw[6:0];
    rd     = iw[11:7];
    funct3 = iw[14:12];
    rs1    = iw[19:15];
    rs2    = iw[24:20];
    funct7 = iw[31:25];
    i_imm  = {{20{iw[31]}}, iw[31:20]};
    s_imm  = {{20{iw[31]}}, iw[31:25], iw[11:7]};
    b_imm  = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
    u_imm  = {iw[31:12], 12'h000};
    j_imm  = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
  end

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; cleared on reset, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (wr_en) begin
      pc_mem[wr_ptr]  <= pc_in;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entry count; legal values 2, 4, 8.
REQ-002 SHALL have parameter XLEN, default 32, width of PC and instruction word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-006 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port pc_in  input  XLEN  PC of the fetched instruction.
REQ-009 SHALL have port imem_rdata  input  XLEN  fetched instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-012 SHALL have port pc_out  output  XLEN  head PC.
REQ-013 SHALL have port imem_rdata_out  output  XLEN  head instruction word.
REQ-014 SHALL have ports opcode 7, funct3 3, funct7 7, rs1 5, rs2 5, rd 5  output  RV32I fields sliced from imem_rdata_out.
REQ-015 SHALL have ports i_imm, s_imm, b_imm, u_imm, j_imm  output  32 each  sign-extended RV32I immediates of imem_rdata_out.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL store entries {pc, instr} in a circular buffer with read pointer, write pointer and occupancy counter.
REQ-018 SHALL perform a push when in_valid && in_ready; a pop when out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH) || out_ready, so a full queue accepts on the same cycle it pops.
REQ-020 SHALL drive out_valid = (count != 0); head outputs reflect the entry at the read pointer.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL wrap pointers from DEPTH-1 to 0.
REQ-023 SHALL, on flush, set count, read and write pointers to 0 at the next edge; a push in the flush cycle is discarded; flush overrides push and pop.
REQ-024 SHALL drive decoded fields combinationally from imem_rdata_out; when out_valid=0 the fields are don't-care but imem_rdata_out SHALL be 0x00000013 (NOP).
REQ-025 SHALL have push-to-out_valid latency of 1 cycle (bypass disabled).
REQ-026 SHALL never overwrite an unpopped entry; count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-027 SHALL, while rst=0, clear count, both pointers and all storage to 0, independent of clk.
REQ-028 SHALL after reset present out_valid=0, in_ready=1, count=0, pc_out=0, imem_rdata_out=0x00000013.
REQ-029 SHALL, on reset asserted mid-operation, discard all entries; the first push after rst rises is the first entry popped.

Configuration
REQ-030 SHALL recognise macro IF_ID_QUEUE_BYPASS_EN.
REQ-031 SHALL, with IF_ID_QUEUE_BYPASS_EN defined, when count=0 and in_valid=1, drive out_valid=1 with pc_in/imem_rdata on head outputs in the same cycle; if out_ready=1 the entry is consumed without being written.
REQ-032 SHALL, without IF_ID_QUEUE_BYPASS_EN, behave per REQ-025 with no combinational in-to-out path.
REQ-033 SHALL, in bypass mode, suppress bypass when flush=1 (out_valid=0 that cycle).

Verification
REQ-034 Reset: rst=0 for 2 cycles mid-traffic -> out_valid=0, count=0, imem_rdata_out=0x00000013, in_ready=1.
REQ-035 Fill/drain DEPTH=4: push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> pops in order 0x00..0x0C over 4 cycles.
REQ-036 Full with concurrent pop: count=4, in_valid=1, out_ready=1, pc_in=0x10 -> in_ready=1, count stays 4, 0x10 popped after 0x0C; pointers wrap.
REQ-037 Flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; pushed entry absent.
REQ-038 Decode: push imem_rdata=0xFE010113 (addi sp,sp,-32) -> opcode=0x13, rd=2, rs1=2, funct3=0, i_imm=0xFFFFFFE0.
REQ-039 Bypass (macro defined): empty queue, in_valid=1, out_ready=1, pc_in=0x80 -> same cycle out_valid=1, pc_out=0x80; next cycle count=0.
